imem_fetch_ctrl: RTL and testbench

- Sequencer and arbiter in front of the single-port instruction memory.
- After reset it gives the memory to the program loader for boot-time writes. Once loading ends, it generates sequential PCs for the core.
- Handles core stalls and branch redirects, and traps out-of-range or misaligned PCs.
- Sits between the loader/debug interface, the core fetch stage and the instruction memory.

---
 rtl/imem_fetch_ctrl.sv | 163 ++++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: arbiter and fetch sequencer for the single-port instruction memory.
// After reset the memory belongs to the program loader. Once the loader signals done,
// the block issues sequential PCs for the core. It absorbs core stalls through a
// one-entry hold buffer, applies branch redirects, and traps misaligned or
// out-of-range PCs into a sticky fault.
//
// Ports:
//   clk, reset (async, active-low)
//   loader : ld_start, ld_valid, ld_ready, ld_addr, ld_data, ld_done
//   core   : stall, redirect_valid, redirect_pc, instr_valid, instr, instr_pc, fault
//   memory : mem_addr, mem_we, mem_wdata, mem_rdata (read data one cycle after mem_addr)
module imem_fetch_ctrl #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SIZE     = 256,
  parameter int unsigned ADDR_W   = $clog2(SIZE),
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [WIDTH-1:0]  ld_data,
  input  logic              ld_done,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              instr_valid,
  output logic [WIDTH-1:0]  instr,
  output logic [31:0]       instr_pc,
  output logic              fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata
);

  localparam logic [31:0] PC_LIMIT = 32'(4 * SIZE);

  typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_FAULT} state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               rd_pend_q, rd_pend_d;
  logic [31:0]        rd_pc_q, rd_pc_d;
  logic               hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0]   hold_data_q, hold_data_d;
  logic [31:0]        hold_pc_q, hold_pc_d;
  logic               fault_q, fault_d;
  logic               load_own;

  // A PC that must never reach the memory.
  function automatic logic pc_bad(input logic [31:0] p);
    return (p[1:0] != 2'b00) || (p >= PC_LIMIT);
  endfunction

  // Loader ownership is qualified by reset so an in-progress write drops asynchronously.
  assign load_own  = (state_q == ST_LOAD) && reset;
  assign ld_ready  = load_own;
  assign mem_we    = load_own && ld_valid;
  assign mem_wdata = load_own ? ld_data : '0;
  assign mem_addr  = load_own ? ld_addr
                   : ((state_q == ST_LOAD) ? '0 : pc_q[ADDR_W+1:2]);

  // A read issued last cycle is shown straight from memory; the hold buffer
  // keeps it stable once a stall has captured it. The two are never both set.
  assign instr_valid = rd_pend_q || hold_valid_q;
  assign instr       = rd_pend_q ? mem_rdata : hold_data_q;
  assign instr_pc    = rd_pend_q ? rd_pc_q : hold_pc_q;
  assign fault       = fault_q;

  // State register and datapath flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_LOAD;
      pc_q         <= RESET_PC;
      rd_pend_q    <= 1'b0;
      rd_pc_q      <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_pc_q    <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      rd_pend_q    <= rd_pend_d;
      rd_pc_q      <= rd_pc_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_pc_q    <= hold_pc_d;
      fault_q      <= fault_d;
    end
  end

  // Next-state, issue, stall capture, redirect and fault handling.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    rd_pend_d    = 1'b0;
    rd_pc_d      = rd_pc_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_pc_d    = hold_pc_q;
    fault_d      = fault_q;

    if (ld_start) begin
      state_d      = ST_LOAD;
      hold_valid_d = 1'b0;
      fault_d      = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (ld_done) begin
            state_d = ST_RUN;
            pc_d    = RESET_PC;
          end
        end
        ST_RUN: begin
          // The shown entry is consumed when stall is low, so a held entry drains
          // in the same cycle that the next read issues and no bubble appears.
          if (stall) begin
            if (rd_pend_q) begin
              hold_valid_d = 1'b1;
              hold_data_d  = mem_rdata;
              hold_pc_d    = rd_pc_q;
            end
          end else begin
            hold_valid_d = 1'b0;
          end

          if (redirect_valid) begin
            hold_valid_d = 1'b0;
            // A bad target faults now and leaves pc (and mem_addr) untouched.
            if (pc_bad(redirect_pc)) begin
              state_d = ST_FAULT;
              fault_d = 1'b1;
            end else begin
              pc_d = redirect_pc;
            end
          end else if (!stall) begin
            if (pc_bad(pc_q)) begin
              state_d      = ST_FAULT;
              fault_d      = 1'b1;
              hold_valid_d = 1'b0;
            end else begin
              rd_pend_d = 1'b1;
              rd_pc_d   = pc_q;
              pc_d      = pc_q + 32'd4;
            end
          end
        end
        ST_FAULT: begin
          hold_valid_d = 1'b0;
        end
        default: begin
          state_d = ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed testbench for imem_fetch_ctrl with a behavioural single-port memory
// (synchronous write, one-cycle read latency).
module tb_imem_fetch_ctrl;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned SIZE   = 256;
  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              ld_start, ld_valid, ld_done;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [WIDTH-1:0]  ld_data;
  logic              stall, redirect_valid;
  logic [31:0]       redirect_pc;
  logic              instr_valid;
  logic [WIDTH-1:0]  instr;
  logic [31:0]       instr_pc;
  logic              fault;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_rdata;

  logic [WIDTH-1:0]  tb_mem [SIZE];
  logic [31:0]       prog [4] = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
  int                n_checks = 0;
  int                n_fail   = 0;

  imem_fetch_ctrl #(
    .WIDTH(WIDTH), .SIZE(SIZE), .ADDR_W(ADDR_W), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .reset(reset),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_done(ld_done),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .fault(fault),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural instruction memory.
  always_ff @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    mem_rdata <= tb_mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic show(input string tag, input logic v, input logic [31:0] pc,
                      input logic [31:0] d);
    chk({tag, ".valid"}, 32'(instr_valid), 32'(v));
    if (v) begin
      chk({tag, ".pc"}, instr_pc, pc);
      chk({tag, ".instr"}, instr, d);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".ld_ready"}, 32'(ld_ready), 0);
    chk({tag, ".valid"}, 32'(instr_valid), 0);
    chk({tag, ".instr"}, instr, 0);
    chk({tag, ".instr_pc"}, instr_pc, 0);
    chk({tag, ".fault"}, 32'(fault), 0);
    chk({tag, ".mem_we"}, 32'(mem_we), 0);
    chk({tag, ".mem_addr"}, 32'(mem_addr), 0);
    chk({tag, ".mem_wdata"}, mem_wdata, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < int'(SIZE); i++) tb_mem[i] = 32'hA000_0000 | 32'(i);
    reset = 1'b0; ld_start = 1'b0; ld_done = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    ld_valid = 1'b1; ld_addr = 8'd5; ld_data = 32'hDEAD_BEEF;
    #3;
    chk_reset_outputs("por");
    tick();
    reset = 1'b1; ld_valid = 1'b0;

    // Boot load of words 0..3
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_addr = 8'(i); ld_data = prog[i];
      smp();
      chk("load.ready", 32'(ld_ready), 1);
      chk("load.we", 32'(mem_we), 1);
      chk("load.addr", 32'(mem_addr), 32'(i));
      tick();
    end
    ld_valid = 1'b0; ld_done = 1'b1;
    smp(); chk("done.ready", 32'(ld_ready), 1); tick();
    ld_done = 1'b0;
    smp(); chk("run.ready", 32'(ld_ready), 0); show("run.first", 1'b0, 0, 0);
    chk("run.addr", 32'(mem_addr), 0); tick();
    smp(); show("boot0", 1'b1, 32'h0, prog[0]); tick();

    // Stall for three cycles while pc 4 is shown
    stall = 1'b1;
    smp(); show("boot1", 1'b1, 32'h4, prog[1]); tick();
    smp(); show("stall1", 1'b1, 32'h4, prog[1]); tick();
    smp(); show("stall2", 1'b1, 32'h4, prog[1]); tick();
    stall = 1'b0;
    smp(); show("release", 1'b1, 32'h4, prog[1]); tick();

    // Redirect to 0x20 while pc 8 is shown
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    smp(); show("boot2", 1'b1, 32'h8, prog[2]); tick();
    redirect_valid = 1'b0;
    smp(); show("redir.bubble", 1'b0, 0, 0); tick();
    smp(); show("redir0", 1'b1, 32'h20, 32'hA000_0008); tick();

    // Redirect with stall: redirect wins
    redirect_valid = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
    smp(); show("redir1", 1'b1, 32'h24, 32'hA000_0009); tick();
    redirect_valid = 1'b0; stall = 1'b0;
    smp(); show("rs.bubble", 1'b0, 0, 0); tick();
    smp(); show("rs0", 1'b1, 32'h40, 32'hA000_0010); tick();

    // Misaligned redirect target faults
    redirect_valid = 1'b1; redirect_pc = 32'h22;
    smp(); show("rs1", 1'b1, 32'h44, 32'hA000_0011);
    chk("pre_fault.addr", 32'(mem_addr), 18); tick();
    redirect_valid = 1'b0;
    smp(); chk("mis.fault", 32'(fault), 1); show("mis", 1'b0, 0, 0);
    chk("mis.addr", 32'(mem_addr), 18); chk("mis.we", 32'(mem_we), 0); tick();

    // Recovery: reload word 0 and restart at RESET_PC
    ld_start = 1'b1;
    smp(); chk("fault.sticky", 32'(fault), 1); tick();
    ld_start = 1'b0; ld_valid = 1'b1; ld_addr = 8'd0; ld_data = 32'h0050_0293;
    smp(); chk("rec.fault", 32'(fault), 0); chk("rec.ready", 32'(ld_ready), 1);
    show("rec", 1'b0, 0, 0); tick();
    ld_valid = 1'b0; ld_done = 1'b1;
    smp(); tick();
    ld_done = 1'b0;
    smp(); show("rec.issue", 1'b0, 0, 0); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h3F8;
    smp(); show("rec0", 1'b1, 32'h0, 32'h0050_0293); chk("rec0.fault", 32'(fault), 0); tick();

    // Sequential fetch off the top of memory
    redirect_valid = 1'b0;
    smp(); show("top.bubble", 1'b0, 0, 0); tick();
    smp(); show("top0", 1'b1, 32'h3F8, 32'hA000_00FE); tick();
    smp(); show("top1", 1'b1, 32'h3FC, 32'hA000_00FF); chk("top1.fault", 32'(fault), 0); tick();
    smp(); chk("wrap.fault", 32'(fault), 1); show("wrap", 1'b0, 0, 0); tick();

    // Back to RUN, then async reset mid-RUN
    ld_start = 1'b1; smp(); tick();
    ld_start = 1'b0; ld_done = 1'b1; smp(); tick();
    ld_done = 1'b0; smp(); tick();
    smp(); show("rerun0", 1'b1, 32'h0, 32'h0050_0293);
    #2 reset = 1'b0;
    #1 chk_reset_outputs("rst_run");
    tick();
    reset = 1'b1;

    // Async reset during a loader write
    ld_valid = 1'b1; ld_addr = 8'd7; ld_data = 32'h1234_5678;
    smp(); chk("ldw.we", 32'(mem_we), 1); chk("ldw.addr", 32'(mem_addr), 7);
    #2 reset = 1'b0;
    #1 chk_reset_outputs("rst_load");
    tick();
    chk("ldw.aborted", tb_mem[7], 32'hA000_0007);
    reset = 1'b1; ld_valid = 1'b0;
    smp(); chk("post_rst.ready", 32'(ld_ready), 1); show("post_rst", 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
